// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built from two half-adder cells and a carry flop, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a SUB input that turns the operation into A - B.

module serial_adder_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StAdd, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic bit_s, bit_c;
  logic last_bit;
  logic start_b_inv;
  logic start_carry;

  // One full-adder slice: two half adders plus an OR on the carries.
  serial_adder_ha u_ha0 (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  serial_adder_ha u_ha1 (
    .a_i (ha0_s),
    .b_i (carry_q),
    .s_o (ha1_s),
    .c_o (ha1_c)
  );

  assign bit_s    = ha1_s;
  assign bit_c    = ha0_c | ha1_c;
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as A + ~B + 1; the +1 enters through the preset carry.
  assign start_b_inv = SUB;
  assign start_carry = SUB;
`else
  assign start_b_inv = 1'b0;
  assign start_carry = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = StAdd;
      StAdd:   if (last_bit) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          a_d     = A;
          b_d     = start_b_inv ? ~B : B;
          carry_d = start_carry;
          cnt_d   = '0;
        end
      end
      StAdd: begin
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d  = {bit_s, res_q[WIDTH-1:1]};
          cout_d = bit_c;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    BUSY = (state_q == StAdd);
    DONE = (state_q == StFin);
    SUM  = sum_q;
    COUT = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); covers SUB when
// SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] SUM;
  logic       COUT;
`ifdef SERIAL_ADDER_SUB_EN
  logic       SUB;
`endif

  int n_cmp;
  int n_err;

  serial_adder #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB   (SUB),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives START for exactly one edge; returns at the negedge following that edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
    @(negedge CLK);
    A     = a;
    B     = b;
`ifdef SERIAL_ADDER_SUB_EN
    SUB   = sub;
`else
    if (sub) $display("note: SUB requested but feature not built");
`endif
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A     = 8'hxx;
    B     = 8'hxx;
  endtask

  // n counts cycles after the START edge (1 on entry); returns at the DONE cycle.
  task automatic wait_done(input logic [7:0] prev_sum, output int n, output int busy_n,
                           output bit held);
    n      = 1;
    busy_n = 0;
    held   = 1'b1;
    while (!DONE && n < 30) begin
      if (BUSY) busy_n++;
      if (SUM !== prev_sum) held = 1'b0;
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic count_dones(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
  endtask

  initial begin
    int  n;
    int  busy_n;
    int  dones;
    bit  held;

    n_cmp = 0;
    n_err = 0;
    RST   = 1'b1;
    START = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
    SUB   = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_val("rst_busy", 32'(BUSY), 32'd0);
    check_val("rst_done", 32'(DONE), 32'd0);
    check_val("rst_sum", 32'(SUM), 32'h00);
    check_val("rst_cout", 32'(COUT), 32'd0);

    // 0 + 0 with latency and BUSY width
    start_op(8'h00, 8'h00, 1'b0);
    wait_done(8'h00, n, busy_n, held);
    check_val("zero_latency", 32'(n), 32'd9);
    check_val("zero_busy_cycles", 32'(busy_n), 32'd8);
    check_val("zero_sum", 32'(SUM), 32'h00);
    check_val("zero_cout", 32'(COUT), 32'd0);
    check_val("fin_busy_low", 32'(BUSY), 32'd0);

    // 0x5A + 0x3C then back-to-back 0xC8 + 0x64 at the earliest START
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(8'h00, n, busy_n, held);
    check_val("add1_sum", 32'(SUM), 32'h96);
    check_val("add1_cout", 32'(COUT), 32'd0);
    start_op(8'hC8, 8'h64, 1'b0);
    wait_done(8'h96, n, busy_n, held);
    check_val("b2b_latency", 32'(n), 32'd9);
    check_val("b2b_sum_held", 32'(held), 32'd1);
    check_val("b2b_sum", 32'(SUM), 32'h2C);
    check_val("b2b_cout", 32'(COUT), 32'd1);

    // Full carry ripple
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(8'h2C, n, busy_n, held);
    check_val("ripple_sum", 32'(SUM), 32'h00);
    check_val("ripple_cout", 32'(COUT), 32'd1);

    // START mid-operation is ignored
    start_op(8'h11, 8'h22, 1'b0);
    repeat (2) @(negedge CLK);
    A     = 8'hFF;
    B     = 8'hFF;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(8'h00, n, busy_n, held);
    check_val("ign_done_seen", 32'(DONE), 32'd1);
    check_val("ign_sum", 32'(SUM), 32'h33);
    check_val("ign_cout", 32'(COUT), 32'd0);
    count_dones(12, dones);
    check_val("ign_single_done", 32'(dones), 32'd0);
    check_val("ign_idle_busy", 32'(BUSY), 32'd0);

    // Reset mid-operation discards the partial result
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_val("midrst_busy", 32'(BUSY), 32'd0);
    check_val("midrst_done", 32'(DONE), 32'd0);
    check_val("midrst_sum", 32'(SUM), 32'h00);
    check_val("midrst_cout", 32'(COUT), 32'd0);
    count_dones(12, dones);
    check_val("midrst_no_done", 32'(dones), 32'd0);
    start_op(8'h01, 8'h02, 1'b0);
    wait_done(8'h00, n, busy_n, held);
    check_val("after_rst_sum", 32'(SUM), 32'h03);
    check_val("after_rst_cout", 32'(COUT), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h10, 8'h01, 1'b1);
    wait_done(8'h03, n, busy_n, held);
    check_val("sub1_sum", 32'(SUM), 32'h0F);
    check_val("sub1_cout", 32'(COUT), 32'd1);
    start_op(8'h00, 8'h01, 1'b1);
    wait_done(8'h0F, n, busy_n, held);
    check_val("sub2_sum", 32'(SUM), 32'hFF);
    check_val("sub2_cout", 32'(COUT), 32'd0);
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(8'hFF, n, busy_n, held);
    check_val("sub0_sum", 32'(SUM), 32'h96);
    check_val("sub0_cout", 32'(COUT), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that uses the existing half-adder cell as its datapath.
- Two half adders plus an OR form one full-adder slice. A carry flip-flop chains the slices across clock cycles.
- Adds one bit per cycle, LSB first, under a START/BUSY/DONE handshake.
- Sits directly downstream of the half adder: it consumes SUM/CARRY each cycle and turns the combinational cell into a multi-bit sequential adder for the FPGA lab top level.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  operand A; latched on the accepted START edge.
- B  input  WIDTH  operand B; latched on the accepted START edge.
- BUSY  output  1  high while an addition is in progress (state ADD).
- DONE  output  1  one-cycle pulse; SUM/COUT are valid.
- SUM  output  WIDTH  registered result; holds until the next completion or reset.
- COUT  output  1  registered final carry; holds like SUM.

Behaviour:
- Reset: if RST is high at a clock edge, then state=IDLE and BUSY=0, DONE=0, SUM=0, COUT=0. Operand shift registers, carry FF and bit counter are all cleared. RST has priority over everything, including mid-operation; the partial result is discarded.
- FSM states: IDLE, ADD, FIN.
- IDLE: on an edge with START=1:
  - load A and B into shift registers;
  - carry FF=0, counter=0;
  - go to ADD, BUSY=1.
  - START=0: stay in IDLE.
- ADD: each edge processes one bit:
  - s = a0 ^ b0 ^ c; cnext = (a0 & b0) | (c & (a0 ^ b0)), using two half-adder instances;
  - s is shifted into the MSB of the internal result shift register; operand registers shift right by one; carry FF <= cnext; counter++.
  - On the WIDTH-th ADD edge (counter = WIDTH-1 before the edge): SUM <= completed result, COUT <= cnext, go to FIN.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then unconditional return to IDLE on the next edge.
- Latency: START is sampled at edge t0. DONE is high in the cycle following edge t0+WIDTH. The next START can be accepted at edge t0+WIDTH+2 or later.
- START while BUSY or in FIN is ignored. A and B changes after the accepted edge have no effect.
- SUM/COUT are never updated partially. Previous results stay visible while BUSY.
- Arithmetic: modulo 2^WIDTH. COUT is the carry out of bit WIDTH-1.
- Outputs are registered or state-decoded only; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port SUB (1 bit), latched with A/B on the accepted START;
  - SUB=1 computes A - B by loading ~B and presetting the carry FF to 1; COUT=1 means no borrow (A >= B unsigned);
  - SUB=0 behaves identically to plain add.
- Undefined: no SUB port, add only; the carry FF always starts at 0.

Test Plan:
- Reset, then START with A=0x00, B=0x00 -> BUSY high for 8 cycles, then DONE one cycle with SUM=0x00, COUT=0; DONE visible exactly 9 edges after the START edge, including the FIN edge.
- A=0x5A, B=0x3C -> SUM=0x96, COUT=0. Then A=0xC8, B=0x64 back-to-back at the earliest legal START -> SUM=0x2C, COUT=1. SUM stays 0x96 throughout the second operation until DONE.
- A=0xFF, B=0x01 -> SUM=0x00, COUT=1 (full carry ripple across all bits).
- START with A=0x11, B=0x22; pulse START again with A=0xFF, B=0xFF at bit 3 -> second START ignored, result SUM=0x33, COUT=0, single DONE pulse.
- START with A=0xAA, B=0x55; assert RST for one edge after bit 4 -> BUSY=0, DONE never asserted, SUM=0, COUT=0. A following START with A=0x01, B=0x02 -> SUM=0x03.
- With SERIAL_ADDER_SUB_EN: SUB=1, A=0x10, B=0x01 -> SUM=0x0F, COUT=1. SUB=1, A=0x00, B=0x01 -> SUM=0xFF, COUT=0.
